dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Single-port data-memory arbiter between the CPU MEM stage (fed by the EX/MEM pipeline register) and the camera frame writer. Grants one memory access per cycle, sequences CPU reads over the memory's one-cycle read latency, and stalls the CPU pipeline while the camera holds the port. A starvation counter guarantees the camera a bounded wait under continuous CPU traffic.

## Interface
Reset is asynchronous and active-high.

Parameters:
- CAM_BURST, 8: maximum camera beats per grant (≥1)
- CAM_WAIT_MAX, 4: refused camera cycles before the camera is forced ahead of the CPU (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  MEM stage has a memory access
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  CPU address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  load data, valid in the cycle load completes
- cpu_stall  out  1  holds the pipeline; access not complete this cycle
- cam_valid  in  1  camera write beat pending
- cam_addr  in  32  camera address
- cam_wdata  in  32  camera data
- cam_ready  out  1  camera beat accepted when cam_valid & cam_ready
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, one cycle after address

## Operation
- States: IDLE, CPU_RD, CAM. `starve` = cam_valid & (wait_cnt == CAM_WAIT_MAX).
- IDLE, cpu_req & !starve:
  - Store: mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_stall=0, stay IDLE.
  - Load: mem_addr=cpu_addr, cpu_stall=1, go to CPU_RD.
- IDLE, cam_valid & (!cpu_req | starve): cam_ready=1, camera write issued, beat_cnt=1, cpu_stall=cpu_req. Go to CAM, or stay IDLE if CAM_BURST==1.
- IDLE, no request: all memory outputs 0.
- CPU_RD: cpu_rdata=mem_rdata, cpu_stall=0, no memory access, go to IDLE.
- CAM:
  - While cam_valid: cam_ready=1, write issued, beat_cnt++. Go to IDLE when beat_cnt reaches CAM_BURST.
  - cam_valid=0: no access, go to IDLE.
  - cpu_stall=cpu_req throughout.
- wait_cnt:
  - Increments each cycle cam_valid=1 without a camera transfer, saturating at CAM_WAIT_MAX.
  - Clears on any camera transfer and when cam_valid=0.
- cpu_rdata is 0 outside CPU_RD.
- cam_ready is 0 outside granted cycles.
- Camera is write-only. Address and data pass through unmodified, full 32 bits, no alignment checks.

## Timing
- Reset (async, any state): state=IDLE, wait_cnt=0, beat_cnt=0.
- During reset: mem_we=0, mem_addr=0, mem_wdata=0, cam_ready=0, cpu_rdata=0, cpu_stall=cpu_req.
- Reset mid-CAM or mid-CPU_RD abandons the access; the CPU retries after reset.
- Latency:
  - CPU store: 0 stall cycles when granted.
  - CPU load: 1 stall cycle; data arrives in the second cycle.
  - Camera beat: accepted in the grant cycle.
- Simultaneous requests in IDLE: CPU wins unless `starve`.
- A load in CPU_RD is never pre-empted.
- Worst-case CPU stall behind the camera: CAM_BURST+1 cycles.
- Worst-case camera wait: CAM_WAIT_MAX cycles, plus 1 if a load is in CPU_RD.
- CAM exits on the cycle beat_cnt==CAM_BURST after the last transfer, so the CPU is served the following cycle.

## Configuration
- DMEM_ARB_PERF_EN defined: adds output ports perf_stall_cnt[31:0] and perf_cam_beats[31:0].
  - perf_stall_cnt counts cycles with cpu_stall=1.
  - perf_cam_beats counts camera transfers.
  - Both wrap at 2^32 and reset to 0.
- Undefined: those ports and their counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- Package dmem_arb_pkg:
  - state enum (IDLE, CPU_RD, CAM)
  - default constants for CAM_BURST and CAM_WAIT_MAX
  - counter-width function $clog2(N+1)
- One sub-module: dmem_arb_perf (the two counters), instantiated only under DMEM_ARB_PERF_EN.
- FSM and arbitration stay in dmem_arbiter.

## Test plan
- CPU store 0x10←0xDEADBEEF, no camera → mem_we=1, mem_addr=0x10 the same cycle, cpu_stall=0.
- CPU load 0x10 with memory returning 0xDEADBEEF → cpu_stall=1 for one cycle, then cpu_rdata=0xDEADBEEF with cpu_stall=0.
- Camera alone, 10 consecutive beats, CAM_BURST=8:
  - 8 beats accepted back-to-back.
  - One cycle with cam_ready=0 (CAM→IDLE).
  - Remaining 2 accepted.
- Continuous CPU stores plus cam_valid held, CAM_WAIT_MAX=4:
  - Camera refused 4 cycles, then granted.
  - cpu_stall=1 during the burst.
  - CPU resumes after the burst.
- Assert reset while in CAM, 3 beats in → cam_ready and mem_we drop immediately, state IDLE, and the next CPU store completes with no stall.
- DMEM_ARB_PERF_EN build, one load plus 8 camera beats → perf_cam_beats=8, perf_stall_cnt equals the observed stall cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Contents: FSM state enum, default burst/wait limits, counter-width helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        CAM    = 2'd2
    } state_t;

    localparam int unsigned CAM_BURST_DEF    = 8;
    localparam int unsigned CAM_WAIT_MAX_DEF = 4;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_perf.sv
// Performance counters for the data-memory arbiter.
// Ports: clk, reset (async, active-high), stall / cam_xfer event strobes,
//        perf_stall_cnt / perf_cam_beats 32-bit wrapping counts.
module dmem_arb_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        cam_xfer,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_cam_beats
);

    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= 32'd0;
            perf_cam_beats <= 32'd0;
        end else begin
            if (stall)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (cam_xfer) perf_cam_beats <= perf_cam_beats + 32'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU MEM stage vs camera frame writer.
// One access per cycle; CPU loads take a second cycle for read data; the
// camera is forced ahead after CAM_WAIT_MAX refused cycles.
// Ports: clk, reset (async, active-high); cpu_req/we/addr/wdata in,
//        cpu_rdata/cpu_stall out; cam_valid/addr/wdata in, cam_ready out;
//        mem_we/addr/wdata out, mem_rdata in.
// Optional: DMEM_ARB_PERF_EN adds perf_stall_cnt and perf_cam_beats outputs.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned CAM_BURST    = CAM_BURST_DEF,
    parameter int unsigned CAM_WAIT_MAX = CAM_WAIT_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        cam_valid,
    input  logic [31:0] cam_addr,
    input  logic [31:0] cam_wdata,
    output logic        cam_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
   ,output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_cam_beats
`endif
);

    localparam int unsigned BW = cnt_width(CAM_BURST);
    localparam int unsigned WW = cnt_width(CAM_WAIT_MAX);

    state_t          state, state_nxt;
    logic [BW-1:0]   beat_cnt, beat_nxt;
    logic [WW-1:0]   wait_cnt, wait_nxt;
    logic            starve;

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    assign starve = cam_valid && (wait_cnt == WW'(CAM_WAIT_MAX));

    // Arbitration, next state and memory-port outputs.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        wait_nxt  = wait_cnt;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        cam_ready = 1'b0;
        cpu_rdata = 32'd0;
        cpu_stall = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_req && !starve) begin
                    mem_addr = cpu_addr;
                    if (cpu_we) begin
                        mem_we    = 1'b1;
                        mem_wdata = cpu_wdata;
                    end else begin
                        cpu_stall = 1'b1;
                        state_nxt = CPU_RD;
                    end
                end else if (cam_valid) begin
                    cam_ready = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cam_addr;
                    mem_wdata = cam_wdata;
                    beat_nxt  = BW'(1);
                    cpu_stall = cpu_req;
                    if (CAM_BURST > 1) state_nxt = CAM;
                end
            end
            CPU_RD: begin
                cpu_rdata = mem_rdata;
                state_nxt = IDLE;
            end
            CAM: begin
                cpu_stall = cpu_req;
                // Burst exhausted or camera idle: spend one cycle returning
                // to IDLE so the CPU is served next.
                if (beat_cnt == BW'(CAM_BURST) || !cam_valid) begin
                    state_nxt = IDLE;
                end else begin
                    cam_ready = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cam_addr;
                    mem_wdata = cam_wdata;
                    beat_nxt  = beat_cnt + BW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are quiet while reset is held; the CPU keeps stalling.
        if (reset) begin
            mem_we    = 1'b0;
            mem_addr  = 32'd0;
            mem_wdata = 32'd0;
            cam_ready = 1'b0;
            cpu_rdata = 32'd0;
            cpu_stall = cpu_req;
        end

        // Starvation counter: counts refused camera cycles, saturating.
        if (!cam_valid || cam_ready) begin
            wait_nxt = '0;
        end else if (wait_cnt != WW'(CAM_WAIT_MAX)) begin
            wait_nxt = wait_cnt + WW'(1);
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic cam_xfer;
    assign cam_xfer = cam_valid & cam_ready;

    dmem_arb_perf u_perf (
        .clk            (clk),
        .reset          (reset),
        .stall          (cpu_stall),
        .cam_xfer       (cam_xfer),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_cam_beats (perf_cam_beats)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model. Inputs change 1 time unit after posedge,
// outputs are sampled on negedge.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int CB = CAM_BURST_DEF;
    localparam int WM = CAM_WAIT_MAX_DEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cam_valid = 1'b0;
    logic [31:0] cam_addr = 32'd0, cam_wdata = 32'd0;
    logic        cam_ready;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt, perf_cam_beats;
`endif

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cam_valid (cam_valid),
        .cam_addr  (cam_addr),
        .cam_wdata (cam_wdata),
        .cam_ready (cam_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
       ,.perf_stall_cnt (perf_stall_cnt),
        .perf_cam_beats (perf_cam_beats)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Bench memory: 256 words indexed by addr[9:2], one-cycle read latency.
    logic [31:0] bmem [0:255];
    logic [31:0] mmem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) begin
            bmem[i] = 32'h5A5A_0000 | 32'(i);
            mmem[i] = 32'h5A5A_0000 | 32'(i);
        end
    end

    always @(posedge clk) begin
        mem_rdata <= bmem[mem_addr[9:2]];
        if (mem_we) bmem[mem_addr[9:2]] <= mem_wdata;
    end

    // Transaction-level model: a pending load, the number of beats in the
    // current camera grant (0 = none), and refused camera cycles.
    bit          m_rd = 1'b0;
    logic [31:0] m_rd_addr = 32'd0;
    int          m_beats = 0;
    int          m_wait = 0;
    int unsigned m_pstall = 0, m_pbeats = 0;

    always @(negedge clk) begin : cmp
        logic        e_we, e_rdy, e_stall;
        logic [31:0] e_addr, e_wdata, e_rdata;
        bit          gcam, starve;
        e_we = 1'b0; e_rdy = 1'b0; e_stall = 1'b0;
        e_addr = 32'd0; e_wdata = 32'd0; e_rdata = 32'd0;
        gcam = 1'b0; starve = 1'b0;

        if (reset) begin
            e_stall = cpu_req;
            m_rd = 1'b0; m_beats = 0; m_wait = 0;
        end else if (m_rd) begin
            e_rdata = mmem[m_rd_addr[9:2]];
            m_rd = 1'b0;
        end else if (m_beats > 0) begin
            e_stall = cpu_req;
            if (m_beats < CB && cam_valid) begin
                gcam = 1'b1;
                m_beats++;
            end else begin
                m_beats = 0;
            end
        end else begin
            starve = cam_valid && (m_wait == WM);
            if (cpu_req && !starve) begin
                e_addr = cpu_addr;
                if (cpu_we) begin
                    e_we = 1'b1; e_wdata = cpu_wdata;
                end else begin
                    e_stall = 1'b1; m_rd = 1'b1; m_rd_addr = cpu_addr;
                end
            end else if (cam_valid) begin
                gcam = 1'b1;
                e_stall = cpu_req;
                m_beats = (CB > 1) ? 1 : 0;
            end
        end
        if (gcam) begin
            e_rdy = 1'b1; e_we = 1'b1; e_addr = cam_addr; e_wdata = cam_wdata;
        end
        if (!reset) m_wait = (cam_valid && !gcam) ? ((m_wait < WM) ? m_wait + 1 : m_wait) : 0;
        if (e_we) mmem[e_addr[9:2]] = e_wdata;

        chk("m_cpu_stall", 32'(cpu_stall), 32'(e_stall));
        chk("m_cam_ready", 32'(cam_ready), 32'(e_rdy));
        chk("m_mem_we",    32'(mem_we),    32'(e_we));
        chk("m_mem_addr",  mem_addr,  e_addr);
        chk("m_mem_wdata", mem_wdata, e_wdata);
        chk("m_cpu_rdata", cpu_rdata, e_rdata);
`ifdef DMEM_ARB_PERF_EN
        if (reset) begin
            chk("m_perf_stall_rst", perf_stall_cnt, 32'd0);
            chk("m_perf_beats_rst", perf_cam_beats, 32'd0);
            m_pstall = 0; m_pbeats = 0;
        end else begin
            chk("m_perf_stall", perf_stall_cnt, 32'(m_pstall));
            chk("m_perf_beats", perf_cam_beats, 32'(m_pbeats));
            m_pstall += 32'(e_stall);
            m_pbeats += 32'(e_rdy);
        end
`endif
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [10:0] rec_cam;
        logic [13:0] rec_r, rec_s;
        int beats;
        int obs;
        logic [10:0] exp_cam;
        logic [13:0] exp_r, exp_s;
        exp_cam = 11'b110_1111_1111;
        exp_r   = 14'b00_1111_1111_0000;
        exp_s   = 14'b01_1111_1111_0000;

        // Reset state: outputs quiet, stall follows cpu_req.
        cpu_req = 1'b1; cpu_we = 1'b0; cam_valid = 1'b1;
        @(negedge clk);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_cam_ready", 32'(cam_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        next_cycle();
        reset = 1'b0; cpu_req = 1'b0; cam_valid = 1'b0;
        next_cycle();

        // CPU store, no camera.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_mem_addr", mem_addr, 32'h10);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_stall", 32'(cpu_stall), 32'd0);
        next_cycle();

        // CPU load of the stored word.
        cpu_we = 1'b0;
        @(negedge clk);
        chk("ld_stall1", 32'(cpu_stall), 32'd1);
        chk("ld_mem_addr", mem_addr, 32'h10);
        chk("ld_mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("ld_stall2", 32'(cpu_stall), 32'd0);
        chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
        next_cycle();
        cpu_req = 1'b0;

        // Camera alone, 10 beats: 8 back-to-back, one gap, 2 more.
        beats = 0;
        for (int i = 0; i < 11; i++) begin
            cam_valid = 1'b1;
            cam_addr  = 32'h100 + 32'(beats * 4);
            cam_wdata = 32'hCA000000 | 32'(beats);
            @(negedge clk);
            rec_cam[i] = cam_ready;
            if (cam_ready) beats++;
            next_cycle();
        end
        chk("cam_pattern", 32'(rec_cam), 32'(exp_cam));
        chk("cam_beats", 32'(beats), 32'd10);
        cam_valid = 1'b0;
        repeat (2) next_cycle();

        // Continuous stores with camera held: 4 refusals, forced burst.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678;
        cam_valid = 1'b1; cam_addr = 32'h200; cam_wdata = 32'h0BAD_F00D;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rec_r[i] = cam_ready;
            rec_s[i] = cpu_stall;
            if (!cpu_stall) chk("mix_store_addr", mem_addr, 32'h40);
            next_cycle();
        end
        chk("mix_cam_ready", 32'(rec_r), 32'(exp_r));
        chk("mix_cpu_stall", 32'(rec_s), 32'(exp_s));
        cpu_req = 1'b0; cam_valid = 1'b0;
        repeat (2) next_cycle();

        // Reset three beats into a camera burst.
        cam_valid = 1'b1; cam_addr = 32'h300;
        repeat (3) next_cycle();
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("rcam_cam_ready", 32'(cam_ready), 32'd0);
        chk("rcam_mem_we", 32'(mem_we), 32'd0);
        chk("rcam_stall", 32'(cpu_stall), 32'd1);
        next_cycle();
        reset = 1'b0; cam_valid = 1'b0;
        @(negedge clk);
        chk("rcam_store_we", 32'(mem_we), 32'd1);
        chk("rcam_store_addr", mem_addr, 32'h50);
        chk("rcam_store_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        cpu_req = 1'b0;

`ifdef DMEM_ARB_PERF_EN
        // One load plus 8 camera beats.
        obs = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); obs += 32'(cpu_stall); next_cycle();
        end
        cpu_req = 1'b0; cam_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); obs += 32'(cpu_stall); next_cycle();
        end
        cam_valid = 1'b0;
        @(negedge clk); obs += 32'(cpu_stall); next_cycle();
        @(negedge clk);
        chk("perf_cam_beats", perf_cam_beats, 32'd8);
        chk("perf_stall_obs", perf_stall_cnt, 32'(obs));
        chk("perf_stall_lit", perf_stall_cnt, 32'd1);
        next_cycle();
`else
        obs = 0;
`endif

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            cpu_req   = ($urandom_range(0, 9) < 8);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 32'($urandom_range(0, 15)) << 2;
            cpu_wdata = $urandom;
            cam_valid = ($urandom_range(0, 9) < 7);
            cam_addr  = 32'($urandom_range(0, 15)) << 2;
            cam_wdata = $urandom;
            next_cycle();
        end

        reset = 1'b0; cpu_req = 1'b0; cam_valid = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
